// File: rtl/id_pkg.sv
// Shared ASCII class bounds and run-state encoding for the identifier FSM and its token tracker.
package id_pkg;

  localparam logic [7:0] CH_UPPER_LO = 8'h41;
  localparam logic [7:0] CH_UPPER_HI = 8'h5A;
  localparam logic [7:0] CH_LOWER_LO = 8'h61;
  localparam logic [7:0] CH_LOWER_HI = 8'h7A;
  localparam logic [7:0] CH_DIGIT_LO = 8'h30;
  localparam logic [7:0] CH_DIGIT_HI = 8'h39;
  localparam logic [7:0] CH_SPACE    = 8'h20;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } run_state_e;

endpackage

// File: rtl/id_token_tracker_if.sv
// Token record channel: valid/ready handshake carrying the run length of a completed identifier.
interface id_token_tracker_if #(
  parameter int LEN_W = 8
);

  logic             tok_valid;
  logic [LEN_W-1:0] tok_len;
  logic             tok_ready;

  modport master (output tok_valid, output tok_len, input tok_ready);
  modport slave  (input tok_valid, input tok_len, output tok_ready);

endinterface

// File: rtl/id_char_class.sv
// Combinational ASCII classifier shared by the identifier FSM and the token tracker; zero latency, no flow control.
module id_char_class
  import id_pkg::*;
(
  input  logic [7:0] char_i,
  output logic       is_alpha_o,
  output logic       is_digit_o
);

  assign is_alpha_o = ((char_i >= CH_UPPER_LO) && (char_i <= CH_UPPER_HI)) ||
                      ((char_i >= CH_LOWER_LO) && (char_i <= CH_LOWER_HI));
  assign is_digit_o = (char_i >= CH_DIGIT_LO) && (char_i <= CH_DIGIT_HI);

endmodule

// File: rtl/id_token_tracker.sv
// Turns the FSM match flag into run-length token records, 1 cycle after the ending delimiter; one-entry buffer,
// completions arriving while full and stalled are dropped and flagged sticky. ID_TOKEN_COUNT_EN adds tok_count_o.
module id_token_tracker
  import id_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [7:0]                char_i,
  input  logic                      match_i,
  id_token_tracker_if.master        tok_if,
  output logic                      overflow_o
`ifdef ID_TOKEN_COUNT_EN
  ,
  output logic [15:0]               tok_count_o
`endif
);

  localparam logic [LEN_W-1:0] LEN_MAX = '1;

  logic             is_alpha;
  logic             is_digit;
  logic             is_alnum;
  logic             complete;
  logic             accept;
  run_state_e       state_q, state_d;
  logic [LEN_W-1:0] run_len_q, run_len_d;
  logic [LEN_W-1:0] tok_len_q, tok_len_d;
  logic             tok_vld_q, tok_vld_d;
  logic             overflow_q, overflow_d;
`ifdef ID_TOKEN_COUNT_EN
  logic [15:0]      count_q, count_d;
`endif

  id_char_class u_char_class (
    .char_i     (char_i),
    .is_alpha_o (is_alpha),
    .is_digit_o (is_digit)
  );

  assign is_alnum = is_alpha | is_digit;

  always_comb begin
    state_d    = state_q;
    run_len_d  = run_len_q;
    tok_vld_d  = tok_vld_q;
    tok_len_d  = tok_len_q;
    overflow_d = overflow_q;
    complete   = (state_q == ST_RUN) && !is_alnum && match_i;
    // A draining consumer frees the slot in the same cycle, so the new record replaces the old one.
    accept     = complete && (!tok_vld_q || tok_if.tok_ready);

    if (is_alnum) begin
      state_d = ST_RUN;
      if (state_q == ST_IDLE)
        run_len_d = LEN_W'(1);
      else if (run_len_q != LEN_MAX)
        run_len_d = run_len_q + 1'b1;
    end else begin
      state_d   = ST_IDLE;
      run_len_d = '0;
    end

    if (accept) begin
      tok_vld_d = 1'b1;
      tok_len_d = run_len_q;
    end else if (complete) begin
      overflow_d = 1'b1;
    end else if (tok_vld_q && tok_if.tok_ready) begin
      tok_vld_d = 1'b0;
    end
  end

`ifdef ID_TOKEN_COUNT_EN
  assign count_d = (accept && (count_q != 16'hFFFF)) ? count_q + 16'd1 : count_q;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      run_len_q  <= '0;
      tok_vld_q  <= 1'b0;
      tok_len_q  <= '0;
      overflow_q <= 1'b0;
`ifdef ID_TOKEN_COUNT_EN
      count_q    <= 16'd0;
`endif
    end else begin
      state_q    <= state_d;
      run_len_q  <= run_len_d;
      tok_vld_q  <= tok_vld_d;
      tok_len_q  <= tok_len_d;
      overflow_q <= overflow_d;
`ifdef ID_TOKEN_COUNT_EN
      count_q    <= count_d;
`endif
    end
  end

  assign tok_if.tok_valid = tok_vld_q;
  assign tok_if.tok_len   = tok_len_q;
  assign overflow_o       = overflow_q;
`ifdef ID_TOKEN_COUNT_EN
  assign tok_count_o      = count_q;
`endif

endmodule

// File: tb/tb_id_token_tracker.sv
// Randomised and directed bench for id_token_tracker at LEN_W=8 and LEN_W=3 against a queue/integer reference model.
module tb_id_token_tracker;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] ch;
  logic       match;
  logic       rdy;
  logic       ovf8, ovf3;
`ifdef ID_TOKEN_COUNT_EN
  logic [15:0] cnt8, cnt3;
`endif

  always #5 clk = ~clk;

  id_token_tracker_if #(.LEN_W(8)) if8 ();
  id_token_tracker_if #(.LEN_W(3)) if3 ();
  assign if8.tok_ready = rdy;
  assign if3.tok_ready = rdy;

  id_token_tracker #(.LEN_W(8)) dut8 (
    .clk        (clk),
    .reset_n    (reset_n),
    .char_i     (ch),
    .match_i    (match),
    .tok_if     (if8),
    .overflow_o (ovf8)
`ifdef ID_TOKEN_COUNT_EN
    ,
    .tok_count_o(cnt8)
`endif
  );

  id_token_tracker #(.LEN_W(3)) dut3 (
    .clk        (clk),
    .reset_n    (reset_n),
    .char_i     (ch),
    .match_i    (match),
    .tok_if     (if3),
    .overflow_o (ovf3)
`ifdef ID_TOKEN_COUNT_EN
    ,
    .tok_count_o(cnt3)
`endif
  );

  int n_chk = 0;
  int n_pass = 0;

  // Reference model: unbounded run counter, per-instance buffer of at most one record.
  int run_cnt;
  int q_len [2][$];
  int last_len [2];
  int m_ovf [2];
  int m_cnt [2];
  int max_len [2] = '{255, 7};
  // Upstream identifier FSM model: letter first, must contain a digit.
  int  f_len;
  bit  f_first_alpha;
  bit  f_has_digit;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
  endtask

  function automatic bit c_digit(input logic [7:0] c);
    return (c >= "0") && (c <= "9");
  endfunction

  function automatic bit c_alpha(input logic [7:0] c);
    return ((c >= "A") && (c <= "Z")) || ((c >= "a") && (c <= "z"));
  endfunction

  function automatic bit fsm_match();
    return (f_len > 0) && f_first_alpha && f_has_digit;
  endfunction

  task automatic model_reset();
    run_cnt = 0;
    f_len = 0; f_first_alpha = 0; f_has_digit = 0;
    for (int i = 0; i < 2; i++) begin
      q_len[i].delete();
      last_len[i] = 0;
      m_ovf[i] = 0;
      m_cnt[i] = 0;
    end
  endtask

  task automatic model_update(input logic [7:0] c, input bit m, input bit r);
    bit an;
    bit comp;
    int len;
    an = c_alpha(c) || c_digit(c);
    comp = (run_cnt > 0) && !an && m;
    for (int i = 0; i < 2; i++) begin
      len = (run_cnt < max_len[i]) ? run_cnt : max_len[i];
      if (comp) begin
        if (q_len[i].size() == 0 || r) begin
          q_len[i].delete();
          q_len[i].push_back(len);
          last_len[i] = len;
          if (m_cnt[i] < 65535) m_cnt[i]++;
        end else begin
          m_ovf[i] = 1;
        end
      end else if (q_len[i].size() != 0 && r) begin
        void'(q_len[i].pop_front());
      end
    end
    run_cnt = an ? run_cnt + 1 : 0;
    if (an) begin
      if (f_len == 0) f_first_alpha = c_alpha(c);
      if (c_digit(c)) f_has_digit = 1;
      f_len++;
    end else begin
      f_len = 0; f_has_digit = 0; f_first_alpha = 0;
    end
  endtask

  task automatic compare();
    chk("vld8", if8.tok_valid, (q_len[0].size() != 0));
    chk("len8", if8.tok_len, last_len[0]);
    chk("ovf8", ovf8, m_ovf[0]);
    chk("vld3", if3.tok_valid, (q_len[1].size() != 0));
    chk("len3", if3.tok_len, last_len[1]);
    chk("ovf3", ovf3, m_ovf[1]);
`ifdef ID_TOKEN_COUNT_EN
    chk("cnt8", cnt8, m_cnt[0]);
    chk("cnt3", cnt3, m_cnt[1]);
`endif
  endtask

  // Called at a falling edge: drive, clock, update model, check at the next falling edge.
  task automatic step(input logic [7:0] c, input bit r, input int mf);
    ch = c;
    rdy = r;
    match = (mf < 0) ? fsm_match() : mf[0];
    @(posedge clk);
    model_update(c, match, r);
    @(negedge clk);
    compare();
  endtask

  task automatic send(input string s, input bit r, input int mf);
    for (int i = 0; i < s.len(); i++) step(s[i], r, mf);
  endtask

  task automatic pulse_reset();
    #2 reset_n = 1'b0;
    #1 model_reset();
    compare();
    chk("rst_vld", if8.tok_valid, 0);
    chk("rst_len", if8.tok_len, 0);
    chk("rst_ovf", ovf8, 0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [7:0] c;
    int k;
    int mf;
    bit r;
    ch = 8'h20; rdy = 1'b0; match = 1'b0; reset_n = 1'b0;
    model_reset();
    #2 compare();
    @(negedge clk);
    reset_n = 1'b1;

    send("ab12 ", 1, -1);
    chk("t1_vld", if8.tok_valid, 1);
    chk("t1_len", if8.tok_len, 4);
    step(8'h20, 1, -1);
    chk("t1_pulse", if8.tok_valid, 0);

    send("abc 123 ", 1, -1);
    chk("t2_vld", if8.tok_valid, 0);

    send("a1 b2 ", 0, -1);
    chk("t3_len", if8.tok_len, 2);
    chk("t3_ovf", ovf8, 1);
    step(8'h20, 1, -1);
    chk("t3_vld", if8.tok_valid, 0);
    chk("t3_ovf_sticky", ovf8, 1);

    send("abcdefghij1 ", 1, -1);
    chk("t4_len8", if8.tok_len, 11);
    chk("t4_len3", if3.tok_len, 7);

    pulse_reset();
    send("x1 ", 0, -1);
    send("yy22", 0, -1);
    step(8'h20, 1, -1);
    chk("t5_vld", if8.tok_valid, 1);
    chk("t5_len", if8.tok_len, 4);
    chk("t5_ovf", ovf8, 0);
`ifdef ID_TOKEN_COUNT_EN
    chk("t5_cnt", cnt8, 2);
`endif
    step(8'h20, 1, -1);

    send("q9 b7 ", 0, -1);
    send("abc", 0, -1);
    pulse_reset();
    send("45 ", 1, -1);
    chk("t6_nomatch", if8.tok_valid, 0);
    send("45", 1, -1);
    step(8'h20, 1, 1);
    chk("t6_len", if8.tok_len, 2);

    for (int n = 0; n < 3000; n++) begin
      k = $urandom_range(0, 9);
      if (k < 3)       c = 8'h61 + 8'($urandom_range(0, 25));
      else if (k < 4)  c = 8'h41 + 8'($urandom_range(0, 25));
      else if (k < 6)  c = 8'h30 + 8'($urandom_range(0, 9));
      else if (k < 8)  c = 8'h20;
      else begin
        case ($urandom_range(0, 7))
          0: c = 8'h2F; 1: c = 8'h3A; 2: c = 8'h40; 3: c = 8'h5B;
          4: c = 8'h60; 5: c = 8'h7B; 6: c = 8'h5F; default: c = 8'h2E;
        endcase
      end
      if (((n / 400) % 2) == 1) r = ($urandom_range(0, 3) == 0);
      else r = ($urandom_range(0, 3) != 0);
      mf = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1)) : -1;
      step(c, r, mf);
      if ((n % 700) == 699) pulse_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
